// File: rtl/im_pkg.sv
// Shared instruction-memory constants and loader state encoding.
package im_pkg;

  localparam logic [31:0] IM_BASE_ADDR   = 32'h0000_3000;
  localparam int unsigned IM_DEPTH_WORDS = 4096;
  localparam int unsigned IM_IDX_W       = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } im_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words (first byte lands in [31:24]).
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] cnt;

  // High in the cycle the fourth byte of a word is being shifted in.
  assign word_full = shift && (cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift) begin
      cnt  <= cnt + 2'd1;
      word <= {word[23:0], data};
    end
  end

endmodule

// File: rtl/im_loader.sv
// Byte-stream loader for the instruction memory write port.
// Optional checksum output guarded by IM_LOADER_CHECKSUM_EN.
module im_loader
  import im_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = IM_DEPTH_WORDS,
  parameter int unsigned IDX_W       = IM_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W:0]   word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             busy,
  output logic             done
`ifdef IM_LOADER_CHECKSUM_EN
  , output logic [31:0]    checksum
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

  im_state_e        state, state_next;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] clamped;
  logic             accept;
  logic             last_word;
  logic             word_full;

  assign clamped   = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
  assign accept    = in_valid && in_ready;
  assign last_word = (CNT_W'(idx) + CNT_W'(1)) == count;
  assign waddr     = BASE_ADDR + 32'({idx, 2'b00});

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == IDLE),
    .shift     (accept),
    .data      (in_byte),
    .word      (wdata),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    we         = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (word_count == '0) ? DONE : RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (word_full) state_next = WRITE;
      end
      WRITE: begin
        we         = 1'b1;
        state_next = last_word ? DONE : RECV;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // idx is left on the final word so waddr keeps the last written address in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        count <= clamped;
        idx   <= '0;
      end else if (state == WRITE && !last_word) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (we) begin
      checksum <= checksum + wdata;
    end
  end
`else
  // No checksum accumulator in this build.
`endif

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] word_count;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int unsigned ready_cycles = 0;

  always #5 clk = ~clk;

  im_loader #(
    .BASE_ADDR   (32'h0000_3000),
    .DEPTH_WORDS (4096),
    .IDX_W       (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done)
`ifdef IM_LOADER_CHECKSUM_EN
    , .checksum (checksum)
`endif
  );

  always @(negedge clk) begin
    if (we) begin
      log_addr.push_back(waddr);
      log_data.push_back(wdata);
    end
    if (in_ready) ready_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [12:0] n);
    start      = 1'b1;
    word_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout observed=no_ready expected=ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[k*8 +: 8]);
      if (gap) step();
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int unsigned base;
    int unsigned rdy0;
    logic [15:0] iw;

    reset = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0; in_byte = '0;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",       {31'd0, we},       32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_waddr",    waddr,             32'h0000_3000);
    chk("rst_wdata",    wdata,             32'h0000_0000);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single word load.
    base = log_addr.size();
    do_start(13'd1);
    chk("t1_busy",     {31'd0, busy},     32'd1);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    send_word(32'h8C01_0004, 1'b0);
    chk("t1_we",       {31'd0, we},       32'd1);
    chk("t1_in_ready_w", {31'd0, in_ready}, 32'd0);
    chk("t1_waddr",    waddr,             32'h0000_3000);
    chk("t1_wdata",    wdata,             32'h8C01_0004);
    step();
    chk("t1_done",     {31'd0, done},     32'd1);
    chk("t1_we_off",   {31'd0, we},       32'd0);
    chk("t1_busy_d",   {31'd0, busy},     32'd1);
    step();
    chk("t1_idle_busy", {31'd0, busy},    32'd0);
    chk("t1_idle_done", {31'd0, done},    32'd0);
    chk("t1_hold_addr", waddr,            32'h0000_3000);
    chk("t1_hold_data", wdata,            32'h8C01_0004);
    chk("t1_nwrites",  log_addr.size() - base, 32'd1);

    // Three words with in_valid low every other cycle.
    base = log_addr.size();
    do_start(13'd3);
    send_word(32'h1122_3344, 1'b1);
    send_word(32'hA5B6_C7D8, 1'b1);
    send_word(32'h0F1E_2D3C, 1'b1);
    wait_done("t2_done");
    chk("t2_nwrites", log_addr.size() - base, 32'd3);
    if (log_addr.size() - base == 3) begin
      chk("t2_a0", log_addr[base],   32'h0000_3000);
      chk("t2_d0", log_data[base],   32'h1122_3344);
      chk("t2_a1", log_addr[base+1], 32'h0000_3004);
      chk("t2_d1", log_data[base+1], 32'hA5B6_C7D8);
      chk("t2_a2", log_addr[base+2], 32'h0000_3008);
      chk("t2_d2", log_data[base+2], 32'h0F1E_2D3C);
    end
    step();
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // Zero-length load goes straight to DONE.
    base = log_addr.size();
    rdy0 = ready_cycles;
    do_start(13'd0);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t3_idle",    {31'd0, busy}, 32'd0);
    chk("t3_nwrites", log_addr.size() - base, 32'd0);
    chk("t3_noready", ready_cycles - rdy0, 32'd0);

    // Oversized count clamps to the store depth.
    base = log_addr.size();
    do_start(13'd5000);
    for (int i = 0; i < 4096; i++) begin
      iw = 16'(i);
      send_word({8'hC0, iw[15:8], iw[7:0], 8'h5A}, 1'b0);
    end
    wait_done("t4_done");
    chk("t4_nwrites", log_addr.size() - base, 32'd4096);
    if (log_addr.size() - base == 4096) begin
      chk("t4_first_addr", log_addr[base],        32'h0000_3000);
      chk("t4_last_addr",  log_addr[base+4095],   32'h0000_6FFC);
      chk("t4_last_data",  log_data[base+4095],   32'hC00F_FF5A);
    end
    step();
    chk("t4_hold_addr", waddr, 32'h0000_6FFC);

    // Reset in the middle of a word.
    base = log_addr.size();
    do_start(13'd4);
    send_byte(8'h77);
    send_byte(8'h66);
    reset = 1'b0;
    #1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_busy",     {31'd0, busy},     32'd0);
    chk("t5_waddr",    waddr,             32'h0000_3000);
    chk("t5_wdata",    wdata,             32'h0000_0000);
    #3;
    reset = 1'b1;
    step();
    do_start(13'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done("t5_done");
    chk("t5_nwrites", log_addr.size() - base, 32'd1);
    if (log_addr.size() - base == 1) begin
      chk("t5_addr", log_addr[base], 32'h0000_3000);
      chk("t5_data", log_data[base], 32'hDEAD_BEEF);
    end
    step();

    // start while busy is ignored.
    base = log_addr.size();
    do_start(13'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    do_start(13'd7);
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h0506_0708, 1'b0);
    wait_done("t6_done");
    chk("t6_nwrites", log_addr.size() - base, 32'd2);
    if (log_addr.size() - base == 2) begin
      chk("t6_d0", log_data[base],   32'h0102_0304);
      chk("t6_a1", log_addr[base+1], 32'h0000_3004);
      chk("t6_d1", log_data[base+1], 32'h0506_0708);
    end
    step();
    chk("t6_idle", {31'd0, busy}, 32'd0);

`ifdef IM_LOADER_CHECKSUM_EN
    do_start(13'd2);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    wait_done("t7_done");
    chk("t7_checksum", checksum, 32'h0000_0000);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
Runtime program writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a big-endian 32-bit word. Each word is written into the instruction store, starting at the text-segment base 0x0000_3000. The block sits between the host/debug byte source and the instruction memory's write port. Instruction fetch reads the memory only after done.

Parameters:
BASE_ADDR, 32'h0000_3000, byte address of instruction word 0
DEPTH_WORDS, 4096, instruction store capacity in words
IDX_W, 12, word-index width (log2 DEPTH_WORDS)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  pulse; begins a load, sampled only in IDLE
word_count  input  13  words to load, latched on start
in_valid  input  1  byte source has data
in_byte  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
we  output  1  instruction-memory write enable, one cycle per word
waddr  output  32  byte address = BASE_ADDR + {idx, 2'b00}
wdata  output  32  packed word
busy  output  1  high in RECV/WRITE/DONE
done  output  1  one-cycle pulse at end of load

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready, we, busy, done all 0; waddr = BASE_ADDR; wdata = 0; idx = 0; byte counter = 0; the count register is cleared.
- States and transitions:
  - IDLE -> RECV on start when the latched count is nonzero.
  - IDLE -> DONE on start when word_count == 0. No writes occur.
  - start in any other state is ignored.
- Count: if word_count > DEPTH_WORDS, it is clamped to DEPTH_WORDS at latch, so waddr never wraps past the store.
- RECV: in_ready = 1. A byte transfers when in_valid && in_ready.
  - The first byte goes to wdata[31:24], then [23:16], [15:8], [7:0] (big-endian, matching code.txt word order).
  - in_valid low stalls with no state change.
  - The cycle after the 4th byte is accepted, the state is WRITE.
- WRITE: in_ready = 0; we = 1 for exactly one cycle; waddr and wdata are stable. Then idx increments.
  - If idx+1 == count -> DONE, else -> RECV.
  - Peak throughput is 1 word per 5 cycles.
- DONE: done = 1 for one cycle, busy still 1; next state IDLE.
- waddr and wdata hold their last values in IDLE; we is 0 outside WRITE.
- Reset mid-load: the partial word is discarded and memory contents already written are untouched. The next load restarts at idx 0.
- A byte presented while not in RECV is not consumed; the source must hold it.

Optional Feature:
IM_LOADER_CHECKSUM_EN:
- Defined: adds output checksum[31:0], a modulo-2^32 sum of every wdata written with we. It is cleared on reset and on an accepted start, and is valid when done pulses.
- Undefined: no port, no adder; behaviour is otherwise identical.

Decomposition:
- Shared package im_pkg:
  - IM_BASE_ADDR, IM_DEPTH_WORDS, IM_IDX_W constants, shared with the instruction memory and the PC reset value.
  - state enum {IDLE, RECV, WRITE, DONE}.
- Sub-module byte_packer: 2-bit byte counter plus 32-bit shift register. Outputs word and a word_full flag, with clear input. The FSM and address counter stay in im_loader.

Test Plan:
- count=1; bytes 8C,01,00,04 -> one we pulse, waddr=0x0000_3000, wdata=0x8C010004; done 1 cycle later; busy low after.
- count=3; 12 bytes, in_valid toggling every other cycle -> waddr 0x3000, 0x3004, 0x3008 in order; no byte lost or duplicated; exactly 3 we pulses.
- count=0; start -> done pulses at cycle 2, we never asserted, in_ready never high.
- count=5000 -> clamped to 4096; last write waddr=0x0000_6FFC, then done.
- Reset low after 2 bytes of word 1 in a count=4 load -> outputs return to reset values immediately. A new load of count=1 writes 0x3000 with only the fresh 4 bytes.
- start pulsed mid-load -> ignored. With IM_LOADER_CHECKSUM_EN, words 0x1,0xFFFFFFFF -> checksum=0x00000000 at done.
